// File: rtl/icb_regfile.sv
// ICB slave register file: byte-maskable control regs, RO status words, start/busy/done engine, sticky IRQ status.
// Latency: response registered at the accept edge (1 cycle); register write effects are visible the next cycle.
// Backpressure: cmd_ready = !rsp_valid | rsp_ready; a stalled response holds its data, and one response is outstanding at most.
module icb_regfile #(
    parameter int ADDR_W   = 12,
    parameter int NUM_CTRL = 4,
    parameter int NUM_STAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icb_cmd_valid,
    output logic                  icb_cmd_ready,
    input  logic                  icb_cmd_read,
    input  logic [31:0]           icb_cmd_addr,
    input  logic [31:0]           icb_cmd_wdata,
    input  logic [3:0]            icb_cmd_wmask,
    output logic                  icb_rsp_valid,
    input  logic                  icb_rsp_ready,
    output logic [31:0]           icb_rsp_rdata,
    output logic                  icb_rsp_err,
    output logic [32*NUM_CTRL-1:0] ctrl_o,
    input  logic [32*NUM_STAT-1:0] stat_i,
    output logic                  start_o,
    output logic                  busy_o,
    input  logic                  done_i,
    output logic                  irq_o
);

    localparam logic [31:0] STAT_BASE_W = 32'd64;   // 0x100 >> 2
    localparam logic [31:0] CMD_W       = 32'd128;  // 0x200 >> 2
    localparam logic [31:0] ISTAT_W     = 32'd129;  // 0x204 >> 2
    localparam logic [31:0] IEN_W       = 32'd130;  // 0x208 >> 2

    logic [31:0]         ctrl_q [NUM_CTRL];
    logic                busy_q;
    logic                start_q;
    logic                irq_q;
    logic [1:0]          irq_stat_q;
    logic [1:0]          irq_en_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;
    logic                rsp_err_q;

    logic                accept;
    logic [ADDR_W-1:0]   off;
    logic [31:0]         word_idx;
    logic [NUM_CTRL-1:0] ctrl_sel;
    logic                hit_ctrl;
    logic                hit_stat;
    logic                hit_cmd;
    logic                hit_istat;
    logic                hit_ien;
    logic                dec_err;
    logic [31:0]         rd_data;
    logic                wr_en;
    logic [31:0]         bmask;
    logic                start_req;
    logic [1:0]          irq_set;
    logic [1:0]          irq_clr;
    logic                unused_addr;

    // Address bits above the decoded window are deliberately ignored.
    assign unused_addr = ^icb_cmd_addr[31:ADDR_W];

    assign icb_cmd_ready = !rsp_valid_q | icb_rsp_ready;
    assign accept        = icb_cmd_valid & icb_cmd_ready;
    assign off           = icb_cmd_addr[ADDR_W-1:0];
    assign word_idx      = 32'(off[ADDR_W-1:2]);

    // Decode the offset and build read data; stat words are sampled as the command is accepted.
    always_comb begin
        ctrl_sel  = '0;
        hit_ctrl  = 1'b0;
        hit_stat  = 1'b0;
        rd_data   = 32'h0;
        hit_cmd   = (word_idx == CMD_W);
        hit_istat = (word_idx == ISTAT_W);
        hit_ien   = (word_idx == IEN_W);
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (word_idx == 32'(i)) begin
                ctrl_sel[i] = 1'b1;
                hit_ctrl    = 1'b1;
                rd_data     = ctrl_q[i];
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (word_idx == STAT_BASE_W + 32'(j)) begin
                hit_stat = 1'b1;
                rd_data  = stat_i[32*j +: 32];
            end
        end
        if (hit_cmd)   rd_data = {31'b0, busy_q};
        if (hit_istat) rd_data = {30'b0, irq_stat_q};
        if (hit_ien)   rd_data = {30'b0, irq_en_q};
        dec_err = (off[1:0] != 2'b00)
                | !(hit_ctrl | hit_stat | hit_cmd | hit_istat | hit_ien)
                | (!icb_cmd_read & hit_stat);
    end

    assign wr_en     = accept & !icb_cmd_read & !dec_err;
    assign bmask     = {{8{icb_cmd_wmask[3]}}, {8{icb_cmd_wmask[2]}},
                        {8{icb_cmd_wmask[1]}}, {8{icb_cmd_wmask[0]}}};
    assign start_req = wr_en & hit_cmd & icb_cmd_wmask[0] & icb_cmd_wdata[0];
    assign irq_set   = {start_req & busy_q, done_i & busy_q};
    assign irq_clr   = (wr_en & hit_istat & icb_cmd_wmask[0]) ? icb_cmd_wdata[1:0] : 2'b00;

    // Control registers: byte-masked writes from accepted, legal commands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= 32'h0;
        end else begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (wr_en & ctrl_sel[i]) ctrl_q[i] <= (ctrl_q[i] & ~bmask) | (icb_cmd_wdata & bmask);
            end
        end
    end

    // Command engine and interrupt state; a set of an IRQ_STAT bit wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            irq_stat_q <= 2'b00;
            irq_en_q   <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            start_q <= start_req & !busy_q;
            if (start_req & !busy_q)  busy_q <= 1'b1;
            else if (done_i & busy_q) busy_q <= 1'b0;
            irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
            if (wr_en & hit_ien & icb_cmd_wmask[0]) irq_en_q <= icb_cmd_wdata[1:0];
            irq_q <= |(irq_stat_q & irq_en_q);
        end
    end

    // Response register: loaded on accept, held while stalled, dropped after a handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= dec_err;
            rsp_rdata_q <= (icb_cmd_read & !dec_err) ? rd_data : 32'h0;
        end else if (icb_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_o
        assign ctrl_o[32*g +: 32] = ctrl_q[g];
    end

    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_rdata = rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;
    assign start_o       = start_q;
    assign busy_o        = busy_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_icb_regfile.sv
// Self-checking bench for icb_regfile: scoreboard of expected responses plus direct output checks.
module tb_icb_regfile;
    localparam int NC = 4;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic          icb_cmd_read;
    logic [31:0]   icb_cmd_addr;
    logic [31:0]   icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [31:0]   icb_rsp_rdata;
    logic          icb_rsp_err;
    logic [32*NC-1:0] ctrl_o;
    logic [32*NS-1:0] stat_i;
    logic          start_o;
    logic          busy_o;
    logic          done_i;
    logic          irq_o;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int start_cnt = 0;
    bit rand_rdy = 1'b0;
    logic [32:0] sb [$];
    logic        stall_prev = 1'b0;
    logic [31:0] prev_rdata;
    logic        prev_err;

    icb_regfile #(.ADDR_W(12), .NUM_CTRL(NC), .NUM_STAT(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .ctrl_o(ctrl_o), .stat_i(stat_i), .start_o(start_o),
        .busy_o(busy_o), .done_i(done_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one command; the expected response is queued at the cycle it is accepted.
    task automatic xfer(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wm, input logic [31:0] erd, input logic eerr);
        int n = 0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wdata;
        icb_cmd_wmask = wm;
        @(negedge clk);
        while (!icb_cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!icb_cmd_ready) check("acc_timeout", 32'(icb_cmd_ready), 32'd1);
        else sb.push_back({eerr, erd});
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            wait_cycles(1);
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        wait_cycles(1);
        done_i = 1'b0;
    endtask

    // Random response backpressure while enabled.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) icb_rsp_ready = 1'($urandom_range(0, 1));
    end

    // Response monitor: in-order scoreboard compare and hold-while-stalled checks.
    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_vld", 32'(icb_rsp_valid), 32'd1);
                check("hold_dat", icb_rsp_rdata, prev_rdata);
                check("hold_err", 32'(icb_rsp_err), 32'(prev_err));
            end
            stall_prev = icb_rsp_valid & !icb_rsp_ready;
            prev_rdata = icb_rsp_rdata;
            prev_err   = icb_rsp_err;
            if (icb_rsp_valid && icb_rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_extra", 32'(sb.size()), 32'd1);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    check("rsp_dat", icb_rsp_rdata, e[31:0]);
                    check("rsp_err", 32'(icb_rsp_err), 32'(e[32]));
                end
            end
        end
    end

    logic [31:0] cval [NC];
    logic [31:0] sval [NS];

    initial begin
        int sc0;
        int t0;
        rst_n = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_read = 1'b0;
        icb_cmd_addr = 32'h0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b1;
        done_i = 1'b0;
        for (int j = 0; j < NS; j++) begin
            sval[j] = 32'h1111_0000 * 32'(j + 1) + 32'(j);
            stat_i[32*j +: 32] = sval[j];
        end
        wait_cycles(3);
        check("rst_rsp_vld", 32'(icb_rsp_valid), 32'd0);
        check("rst_rsp_dat", icb_rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(icb_rsp_err), 32'd0);
        for (int i = 0; i < NC; i++) check("rst_ctrl", ctrl_o[32*i +: 32], 32'h0);
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        rst_n = 1'b1;
        wait_cycles(1);
        xfer(1'b1, 32'h204, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1'b1, 32'h208, 32'h0, 4'h0, 32'h0, 1'b0);

        // Masked writes, no-op write, upper address bits ignored.
        xfer(1'b0, 32'h004, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 32'h004, 32'hFFFF_FFFF, 4'h2, 32'h0, 1'b0);
        xfer(1'b1, 32'h004, 32'h0, 4'h0, 32'hA5A5_FF34, 1'b0);
        xfer(1'b0, 32'h004, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1'b1, 32'h1000_0004, 32'h0, 4'h0, 32'hA5A5_FF34, 1'b0);
        wait_cycles(1);
        check("ctrl1_o", ctrl_o[63:32], 32'hA5A5_FF34);
        check("ctrl0_o", ctrl_o[31:0], 32'h0);

        // Error responses with no state change.
        xfer(1'b1, 32'h0FC, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(1'b1, 32'h102, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(1'b0, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
        xfer(1'b0, 32'h006, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        xfer(1'b0, 32'h20C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        xfer(1'b1, 32'h004, 32'h0, 4'h0, 32'hA5A5_FF34, 1'b0);
        xfer(1'b1, 32'h100, 32'h0, 4'h0, sval[0], 1'b0);

        // Start / busy / done engine.
        sc0 = start_cnt;
        xfer(1'b0, 32'h200, 32'h1, 4'h1, 32'h0, 1'b0);
        check("start_hi", 32'(start_o), 32'd1);
        check("busy_set", 32'(busy_o), 32'd1);
        wait_cycles(1);
        check("start_lo", 32'(start_o), 32'd0);
        xfer(1'b1, 32'h200, 32'h0, 4'h0, 32'h1, 1'b0);
        xfer(1'b0, 32'h200, 32'h1, 4'h1, 32'h0, 1'b0);
        wait_cycles(2);
        check("start_cnt", 32'(start_cnt - sc0), 32'd1);
        xfer(1'b1, 32'h204, 32'h0, 4'h0, 32'h2, 1'b0);
        pulse_done();
        check("busy_clr", 32'(busy_o), 32'd0);
        xfer(1'b1, 32'h204, 32'h0, 4'h0, 32'h3, 1'b0);
        xfer(1'b1, 32'h200, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1'b0, 32'h204, 32'h3, 4'h1, 32'h0, 1'b0);
        pulse_done();
        xfer(1'b1, 32'h204, 32'h0, 4'h0, 32'h0, 1'b0);

        // Interrupt enable, set-wins-over-clear, W1C drop timing.
        xfer(1'b0, 32'h208, 32'hFFFF_FFF1, 4'hF, 32'h0, 1'b0);
        xfer(1'b1, 32'h208, 32'h0, 4'h0, 32'h1, 1'b0);
        check("irq_off", 32'(irq_o), 32'd0);
        xfer(1'b0, 32'h200, 32'h1, 4'h1, 32'h0, 1'b0);
        pulse_done();
        wait_cycles(1);
        check("irq_on", 32'(irq_o), 32'd1);
        xfer(1'b0, 32'h200, 32'h1, 4'h1, 32'h0, 1'b0);
        done_i = 1'b1;
        xfer(1'b0, 32'h204, 32'h1, 4'h1, 32'h0, 1'b0);
        done_i = 1'b0;
        check("busy_clr2", 32'(busy_o), 32'd0);
        xfer(1'b1, 32'h204, 32'h0, 4'h0, 32'h1, 1'b0);
        xfer(1'b0, 32'h204, 32'h1, 4'h1, 32'h0, 1'b0);
        check("irq_hold", 32'(irq_o), 32'd1);
        wait_cycles(1);
        check("irq_fall", 32'(irq_o), 32'd0);

        // Back-to-back reads under random backpressure, then at full rate.
        for (int i = 0; i < NC; i++) begin
            cval[i] = 32'h1000_0000 + 32'h0101_0111 * 32'(i);
            xfer(1'b0, 32'(4 * i), cval[i], 4'hF, 32'h0, 1'b0);
        end
        rand_rdy = 1'b1;
        for (int j = 0; j < NS; j++) xfer(1'b1, 32'h100 + 32'(4 * j), 32'h0, 4'h0, sval[j], 1'b0);
        for (int i = 0; i < NC; i++) xfer(1'b1, 32'(4 * i), 32'h0, 4'h0, cval[i], 1'b0);
        rand_rdy = 1'b0;
        icb_rsp_ready = 1'b1;
        drain();
        t0 = cyc;
        for (int j = 0; j < NS; j++) xfer(1'b1, 32'h100 + 32'(4 * j), 32'h0, 4'h0, sval[j], 1'b0);
        for (int i = 0; i < NC; i++) xfer(1'b1, 32'(4 * i), 32'h0, 4'h0, cval[i], 1'b0);
        check("throughput", 32'(cyc - t0), 32'd8);
        drain();

        // Reset while busy, with a start pulse in flight and a response pending.
        icb_rsp_ready = 1'b0;
        xfer(1'b0, 32'h200, 32'h1, 4'h1, 32'h0, 1'b0);
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        wait_cycles(1);
        sb.delete();
        check("mrst_rsp_vld", 32'(icb_rsp_valid), 32'd0);
        check("mrst_rsp_dat", icb_rsp_rdata, 32'h0);
        check("mrst_rsp_err", 32'(icb_rsp_err), 32'd0);
        check("mrst_start", 32'(start_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_irq", 32'(irq_o), 32'd0);
        for (int i = 0; i < NC; i++) check("mrst_ctrl", ctrl_o[32*i +: 32], 32'h0);
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        wait_cycles(1);
        xfer(1'b1, 32'h208, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1'b1, 32'h204, 32'h0, 4'h0, 32'h0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icb_regfile.md
# icb_regfile

Parametrised ICB slave register file for accelerator control: the next generation of the conv block's register interface. It provides NUM_CTRL byte-maskable read/write control registers, NUM_STAT read-only status inputs, a start/busy/done command engine with sticky, maskable interrupt status, and error responses on unmapped or illegal accesses. It sits between the SoC ICB fabric and an accelerator core, such as the conv engine, and supports back-to-back transactions with one response outstanding.

## Interface
- ADDR_W, 12: number of offset bits decoded from icb_cmd_addr; upper bits are ignored.
- NUM_CTRL, 4: number of 32-bit RW control registers (1..64).
- NUM_STAT, 4: number of 32-bit RO status words (1..64).
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- icb_cmd_valid  in  1  command valid.
- icb_cmd_ready  out  1  command ready.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_addr  in  32  byte address; only [ADDR_W-1:0] is decoded.
- icb_cmd_wdata  in  32  write data.
- icb_cmd_wmask  in  4  byte enables; bit k enables wdata[8k+7:8k].
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response ready.
- icb_rsp_rdata  out  32  read data; 0 for writes and errors.
- icb_rsp_err  out  1  error flag, qualified by icb_rsp_valid.
- ctrl_o  out  32*NUM_CTRL  control registers; register i is ctrl_o[32i+31:32i].
- stat_i  in  32*NUM_STAT  status words from the core.
- start_o  out  1  one-cycle start pulse to the core.
- busy_o  out  1  core running.
- done_i  in  1  one-cycle completion pulse from the core.
- irq_o  out  1  registered interrupt, level.

## Operation
- Accept condition: icb_cmd_valid & icb_cmd_ready.
- Address map (offset = addr[ADDR_W-1:0], word-aligned; addr[1:0] ≠ 0 is an error):
  - 0x000 + 4i, i < NUM_CTRL: CTRL[i], RW.
  - 0x100 + 4j, j < NUM_STAT: STAT[j], RO, returns stat_i word j sampled at accept.
  - 0x200: CMD. Read returns {31'b0, busy}. A write with wmask[0] & wdata[0] issues start.
  - 0x204: IRQ_STAT, bits [1:0] = {start_err, done}. Write-1-to-clear, gated by wmask[0].
  - 0x208: IRQ_EN, bits [1:0] RW. Other bits read 0.
- Error cases, each giving rsp_err = 1 and rdata = 0 with no state change:
  - any unmapped offset;
  - misaligned offset;
  - a write to STAT.
- Masked writes: only enabled bytes update; wmask = 0 is a legal no-op write with err = 0.
- Start handling:
  - Start while !busy: start_o pulses for 1 cycle, the cycle after accept, and busy sets at the same edge.
  - Start while busy: no pulse; IRQ_STAT[1] sets.
- Completion: done_i while busy clears busy and sets IRQ_STAT[0]. done_i while !busy is ignored.
- Simultaneous set and clear of the same IRQ_STAT bit: set wins.
- irq_o is the register of |(IRQ_STAT & IRQ_EN), updated every cycle.

## Timing
- icb_cmd_ready = !icb_rsp_valid | icb_rsp_ready, combinational. At most one response is outstanding.
- Response latency is 1 cycle: rsp_valid, rsp_rdata and rsp_err are registered at the accept edge.
- While rsp_valid & !rsp_ready: rdata and err hold stable and no new command is accepted.
- Throughput: with rsp_ready held at 1, one transaction per cycle.
- rsp_valid clears on a handshake unless a new command is accepted in the same cycle.
- Register write effects (ctrl_o, IRQ_EN, IRQ_STAT) are visible the cycle after accept.
- A read in the cycle after a write to the same register returns the new value.
- Reset values:
  - icb_rsp_valid = 0, icb_rsp_rdata = 0, icb_rsp_err = 0;
  - ctrl_o = 0, start_o = 0, busy_o = 0, irq_o = 0;
  - IRQ_STAT = 0, IRQ_EN = 0.
- Reset mid-operation: a pending response is dropped, busy clears, and any pulse in flight is suppressed.

## Test plan
- Write 0xA5A5_1234 to CTRL[1] with wmask 0xF, then write 0xFFFF_FFFF with wmask 0x2, then read CTRL[1] -> rdata 0xA5A5_FF34, err 0; ctrl_o[63:32] matches.
- Read 0x0FC, read 0x102 and write 0x100 -> each returns err = 1 and rdata 0; no register changes.
- Write CMD = 1 -> start_o high for exactly 1 cycle and busy_o = 1. Write CMD = 1 again -> no start_o pulse and IRQ_STAT = 0x2. Pulse done_i -> busy_o = 0 and IRQ_STAT = 0x3.
- Set IRQ_EN = 0x1 and complete a job -> irq_o = 1. Write IRQ_STAT = 0x1 in the same cycle as a new done_i -> bit stays 1. Write IRQ_STAT = 0x1 again -> irq_o falls 1 cycle later.
- Issue 8 back-to-back reads of STAT[0..3] and CTRL[0..3] with rsp_ready randomly low -> responses arrive in order, each held stable while stalled, and the data matches; with rsp_ready = 1, one response per cycle.
- Assert rst_n low while busy and a response is pending -> next cycle all outputs are at reset values.
